// File: rtl/cpu_pkg.sv
// Shared CPU-block definitions: default widths and the program-loader state encoding.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_ADDR_W = 4;

  typedef enum logic [1:0] {
    LDR_IDLE = 2'd0,
    LDR_LOAD = 2'd1,
    LDR_DONE = 2'd2
  } ldr_state_e;

endpackage

// File: rtl/prog_loader.sv
// Program loader: accepts a valid/ready byte stream and emits sequential write
// strobes from address 0 up to DEPTH-1, pulsing done after the final word.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode_i,
  input  logic              prog_valid_i,
  input  logic [DATA_W-1:0] prog_data_i,
  output logic              prog_ready_o,
  output logic              prog_done_o,
  output logic              prog_busy_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  ldr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              done_q, done_d;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    done_d       = 1'b0;
    prog_ready_o = 1'b0;
    prog_busy_o  = 1'b0;
    wr_en_o      = 1'b0;

    unique case (state_q)
      LDR_IDLE: begin
        if (prog_mode_i) begin
          state_d = LDR_LOAD;
          ptr_d   = '0;
        end
      end
      LDR_LOAD: begin
        prog_busy_o = 1'b1;
        if (!prog_mode_i) begin
          // Abort: keep written words, next entry restarts at address 0.
          state_d = LDR_IDLE;
          ptr_d   = '0;
        end else begin
          prog_ready_o = 1'b1;
          if (prog_valid_i) begin
            wr_en_o = 1'b1;
            ptr_d   = ptr_q + ADDR_W'(1);
            if (ptr_q == LastAddr) begin
              state_d = LDR_DONE;
              done_d  = 1'b1;
              ptr_d   = '0;
            end
          end
        end
      end
      LDR_DONE: begin
        if (!prog_mode_i) begin
          state_d = LDR_IDLE;
        end
      end
      default: begin
        state_d = LDR_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign wr_addr_o   = ptr_q;
  assign wr_data_o   = prog_data_i;
  assign prog_done_o = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LDR_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/prog_ram.sv
// CPU RAM block: DEPTH x DATA_W register file with MAR, combinational bus read,
// CPU write port and a hardware program loader that owns the write port in program mode.
module prog_ram
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic              mar_load,
  input  logic              ram_in,
  input  logic              ram_out,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              prog_busy,
  output logic              err_conflict
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic              err_q, err_d;

  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_data;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_en;

  prog_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .prog_mode_i  (prog_mode),
    .prog_valid_i (prog_valid),
    .prog_data_i  (prog_data),
    .prog_ready_o (prog_ready),
    .prog_done_o  (prog_done),
    .prog_busy_o  (prog_busy),
    .wr_en_o      (ldr_we),
    .wr_addr_o    (ldr_addr),
    .wr_data_o    (ldr_data)
  );

  assign cpu_en = ~prog_mode;

  always_comb begin
    mar_d = mar_q;
    if (mar_load && cpu_en) begin
      mar_d = bus_in[ADDR_W-1:0];
    end
    err_d = err_q | (ram_in & ram_out & cpu_en);
  end

  // Program mode hands the single write port to the loader; a CPU write uses the old MAR.
  always_comb begin
    if (prog_mode) begin
      mem_we    = ldr_we;
      mem_waddr = ldr_addr;
      mem_wdata = ldr_data;
    end else begin
      mem_we    = ram_in & ~ram_out;
      mem_waddr = mar_q;
      mem_wdata = bus_in;
    end
  end

  assign bus_oe       = ram_out & cpu_en;
  assign bus_out      = bus_oe ? mem_q[mar_q] : '0;
  assign err_conflict = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mar_q <= '0;
      err_q <= 1'b0;
    end else begin
      mar_q <= mar_d;
      err_q <= err_d;
    end
  end

  // Contents survive reset; only writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_prog_ram.sv
// Randomised scoreboard bench for prog_ram: reads are queued with model data and
// checked by a negedge monitor; control/status outputs are checked inline.
module tb_prog_ram;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mar_load, ram_in, ram_out;
  logic              prog_mode, prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_ready, prog_done, prog_busy, err_conflict;

  prog_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .mar_load     (mar_load),
    .ram_in       (ram_in),
    .ram_out      (ram_out),
    .prog_mode    (prog_mode),
    .prog_valid   (prog_valid),
    .prog_data    (prog_data),
    .prog_ready   (prog_ready),
    .prog_done    (prog_done),
    .prog_busy    (prog_busy),
    .err_conflict (err_conflict)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Reference model
  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                ref_mar;
  logic [DATA_W-1:0] rd_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: bus enable rule every cycle, read data popped from the scoreboard.
  always @(negedge clk) begin
    logic exp_oe;
    exp_oe = ram_out && !prog_mode;
    chk("bus_oe", {31'd0, bus_oe}, {31'd0, exp_oe});
    if (bus_oe) begin
      if (rd_q.size() == 0) begin
        chk("unexpected_read", 32'd1, 32'd0);
      end else begin
        logic [DATA_W-1:0] e;
        e = rd_q.pop_front();
        chk("read_data", {24'd0, bus_out}, {24'd0, e});
      end
    end else begin
      chk("bus_out_idle", {24'd0, bus_out}, 32'd0);
    end
    if (prog_done) done_cnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mar(input int addr);
    mar_load = 1'b1;
    bus_in   = DATA_W'($urandom_range(0, 15) << 4) | DATA_W'(addr);
    cyc();
    mar_load = 1'b0;
    ref_mar  = addr;
  endtask

  task automatic read_cur();
    ram_out = 1'b1;
    rd_q.push_back(ref_mem[ref_mar]);
    cyc();
    ram_out = 1'b0;
  endtask

  task automatic cpu_read(input int addr);
    set_mar(addr);
    read_cur();
  endtask

  task automatic cpu_write(input int addr, input logic [DATA_W-1:0] d);
    set_mar(addr);
    ram_in = 1'b1;
    bus_in = d;
    cyc();
    ram_in = 1'b0;
    ref_mem[addr] = d;
  endtask

  // Streams n bytes (base+k) at addresses start.. with random valid gaps; loader must be in LOAD.
  task automatic stream(input int start, input int n, input logic [DATA_W-1:0] base);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 200) begin
      prog_valid = ($urandom_range(0, 2) != 0);
      prog_data  = base + DATA_W'(k);
      @(negedge clk);
      chk("ready_in_load", {31'd0, prog_ready}, 32'd1);
      chk("busy_in_load", {31'd0, prog_busy}, 32'd1);
      if (prog_valid) begin
        ref_mem[start + k] = prog_data;
        k++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    chk("stream_budget", k, n);
    prog_valid = 1'b0;
  endtask

  task automatic enter_prog();
    prog_mode = 1'b1;
    @(negedge clk);
    chk("ready_idle", {31'd0, prog_ready}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; bus_in = '0; mar_load = 0; ram_in = 0; ram_out = 0;
    prog_mode = 0; prog_valid = 0; prog_data = '0;
    ref_mar = 0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, prog_ready}, 32'd0);
    chk("rst_done", {31'd0, prog_done}, 32'd0);
    chk("rst_busy", {31'd0, prog_busy}, 32'd0);
    chk("rst_err", {31'd0, err_conflict}, 32'd0);
    cyc();

    // Basic CPU access
    cpu_write(5, 8'hA7);
    cpu_read(5);
    for (int i = 0; i < 6; i++) cpu_write($urandom_range(0, 15), DATA_W'($urandom));
    for (int i = 0; i < 6; i++) cpu_read(ref_mar);

    // Full program load
    set_mar(9);
    d0 = done_cnt;
    enter_prog();
    stream(0, DEPTH, 8'h10);
    @(negedge clk);
    chk("done_pulse", {31'd0, prog_done}, 32'd1);
    chk("ready_done", {31'd0, prog_ready}, 32'd0);
    chk("busy_done", {31'd0, prog_busy}, 32'd0);
    cyc();
    @(negedge clk);
    chk("done_one_cycle", {31'd0, prog_done}, 32'd0);
    cyc(); cyc();
    prog_mode = 1'b0;
    cyc();
    chk("done_count_full", done_cnt - d0, 32'd1);
    read_cur();  // MAR kept its pre-programming value
    for (int a = 0; a < DEPTH; a++) cpu_read(a);

    // Aborted load
    d0 = done_cnt;
    enter_prog();
    stream(0, 5, 8'hE0);
    prog_mode = 1'b0;
    cyc();
    @(negedge clk);
    chk("abort_busy", {31'd0, prog_busy}, 32'd0);
    chk("abort_ready", {31'd0, prog_ready}, 32'd0);
    cyc();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    for (int a = 0; a < DEPTH; a++) cpu_read(a);
    enter_prog();
    stream(0, 1, 8'h55);
    prog_mode = 1'b0;
    cyc(); cyc();
    cpu_read(0);
    cpu_read(1);

    // Conflict
    cpu_write(3, 8'h44);
    ram_in = 1'b1; ram_out = 1'b1; bus_in = 8'h99;
    rd_q.push_back(ref_mem[3]);
    cyc();
    ram_in = 1'b0; ram_out = 1'b0;
    @(negedge clk);
    chk("err_set", {31'd0, err_conflict}, 32'd1);
    cpu_read(3);
    cpu_write(6, 8'h3C);
    @(negedge clk);
    chk("err_sticky", {31'd0, err_conflict}, 32'd1);
    cyc();

    // Mode isolation
    set_mar(7);
    enter_prog();
    bus_in = 8'h0F;
    mar_load = 1'b1; cyc(); mar_load = 1'b0;
    ram_in = 1'b1; cyc(); ram_in = 1'b0;
    ram_out = 1'b1; cyc(); ram_out = 1'b0;
    prog_mode = 1'b0;
    cyc();
    read_cur();
    cpu_read(15);

    // Reset mid-load
    enter_prog();
    stream(0, 3, 8'hC0);
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_mid_ready", {31'd0, prog_ready}, 32'd0);
    chk("rst_mid_busy", {31'd0, prog_busy}, 32'd0);
    chk("rst_mid_err", {31'd0, err_conflict}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    prog_mode = 1'b0;
    cyc(); cyc();
    ref_mar = 0;
    read_cur();  // MAR cleared to 0
    cpu_read(1);
    cpu_read(2);
    cpu_read(3);

    cyc(); cyc();
    chk("scoreboard_empty", rd_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
